// File: rtl/vr_setpoint_ctrl_pkg.sv
// Shared constants, channel map and FSM encoding for the vr setpoint sequencer,
// the vr step-engine wrapper and the host register block.
package vr_setpoint_ctrl_pkg;

    localparam int NUM_CH  = 6;
    localparam int POS_W   = 6;
    localparam int MAX_POS = 63;
    localparam int TO_CYC  = 15;
    localparam int CH_W    = 3;
    localparam int TO_W    = $clog2(TO_CYC + 1);

    localparam logic [CH_W-1:0] R_GAIN       = 3'd0;
    localparam logic [CH_W-1:0] G_GAIN       = 3'd1;
    localparam logic [CH_W-1:0] B_GAIN       = 3'd2;
    localparam logic [CH_W-1:0] R_REF        = 3'd3;
    localparam logic [CH_W-1:0] G_REF        = 3'd4;
    localparam logic [CH_W-1:0] B_REF        = 3'd5;
    localparam logic [CH_W-1:0] VR_ADDR_NONE = 3'b111;
    localparam logic [CH_W-1:0] LAST_CH      = CH_W'(NUM_CH - 1);

    localparam logic [POS_W-1:0] MAX_V = POS_W'(MAX_POS);

    typedef enum logic [2:0] {
        ST_HOME_SEL,
        ST_ISSUE,
        ST_WAIT_LO,
        ST_WAIT_HI,
        ST_SCAN,
        ST_ERR
    } vr_state_e;

    function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] d);
        return (d > MAX_V) ? MAX_V : d;
    endfunction

endpackage

// File: rtl/vr_setpoint_ctrl_if.sv
// Host target/readback bus plus the vr step-engine handshake.
// master = sequencer side, slave = host regs and vr engine side.
interface vr_setpoint_ctrl_if;
    import vr_setpoint_ctrl_pkg::*;

    logic             wr_en;
    logic [CH_W-1:0]  wr_addr;
    logic [POS_W-1:0] wr_data;
    logic [CH_W-1:0]  rd_addr;
    logic [POS_W-1:0] rd_data;
    logic             busy;
    logic             homed;
    logic             err;
    logic [CH_W-1:0]  vr_addr;
    logic             vr_ud;
    logic             vr_start;
    logic             vr_ready;

    modport master (
        input  wr_en, wr_addr, wr_data, rd_addr, vr_ready,
        output rd_data, busy, homed, err, vr_addr, vr_ud, vr_start
    );

    modport slave (
        output wr_en, wr_addr, wr_data, rd_addr, vr_ready,
        input  rd_data, busy, homed, err, vr_addr, vr_ud, vr_start
    );

endinterface

// File: rtl/vr_setpoint_ctrl_rr_pick.sv
// Rotate-priority picker: first pending channel strictly after the last grant,
// wrapping around; combinational.
module vr_rr_pick
    import vr_setpoint_ctrl_pkg::*;
(
    input  logic [NUM_CH-1:0] i_pend,
    input  logic [CH_W-1:0]   i_last,
    output logic [CH_W-1:0]   o_grant,
    output logic              o_valid
);

    logic [CH_W-1:0] w_idx;

    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            w_idx = CH_W'((32'(i_last) + k) % NUM_CH);
            if (!o_valid && i_pend[w_idx]) begin
                o_valid = 1'b1;
                o_grant = w_idx;
            end
        end
    end

endmodule

// File: rtl/vr_setpoint_ctrl.sv
// Closed-loop wiper sequencer: homes all six vr channels after reset, then
// steps each tracked position toward its host target one step at a time.
module vr_setpoint_ctrl
    import vr_setpoint_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    vr_setpoint_ctrl_if.master bus
);

    vr_state_e        r_state;
    logic [POS_W-1:0] r_pos [NUM_CH];
    logic [POS_W-1:0] r_tgt [NUM_CH];
    logic [CH_W-1:0]  r_ch;
    logic [CH_W-1:0]  r_last;
    logic [POS_W-1:0] r_home_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic [CH_W-1:0]  r_vr_addr;
    logic             r_vr_ud;
    logic             r_vr_start;
    logic             r_busy;
    logic             r_homed;
    logic             r_err;
    logic [POS_W-1:0] r_rd_data;

    logic [NUM_CH-1:0] w_pend;
    logic [CH_W-1:0]   w_grant;
    logic              w_grant_vld;
    logic              w_timeout;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pend
        assign w_pend[g] = (r_tgt[g] != r_pos[g]);
    end

    assign w_timeout = (r_to_cnt == TO_W'(TO_CYC));

    vr_rr_pick u_pick (
        .i_pend  (w_pend),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_valid (w_grant_vld)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_HOME_SEL;
            r_pos      <= '{default: '0};
            r_tgt      <= '{default: '0};
            r_ch       <= '0;
            r_last     <= LAST_CH;
            r_home_cnt <= '0;
            r_to_cnt   <= '0;
            r_vr_addr  <= VR_ADDR_NONE;
            r_vr_ud    <= 1'b0;
            r_vr_start <= 1'b0;
            r_busy     <= 1'b0;
            r_homed    <= 1'b0;
            r_err      <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_vr_start <= 1'b0;
            r_busy     <= !(r_homed && (r_state == ST_SCAN) && (w_pend == '0));
            r_rd_data  <= (bus.rd_addr <= LAST_CH) ? r_pos[bus.rd_addr] : '0;

            // Host writes land in any state; the next SCAN decision sees them.
            if (bus.wr_en && (bus.wr_addr <= LAST_CH)) begin
                r_tgt[bus.wr_addr] <= clamp_pos(bus.wr_data);
            end

            case (r_state)
                ST_HOME_SEL: begin
                    r_vr_addr <= r_ch;
                    r_vr_ud   <= 1'b0;
                    r_state   <= ST_ISSUE;
                end
                ST_SCAN: begin
                    if (w_grant_vld) begin
                        r_ch      <= w_grant;
                        r_last    <= w_grant;
                        r_vr_addr <= w_grant;
                        r_vr_ud   <= (r_tgt[w_grant] > r_pos[w_grant]);
                        r_state   <= ST_ISSUE;
                    end else begin
                        r_vr_addr <= VR_ADDR_NONE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.vr_ready) begin
                        r_vr_start <= 1'b1;
                        r_to_cnt   <= '0;
                        r_state    <= ST_WAIT_LO;
                    end
                end
                ST_WAIT_LO: begin
                    // vr_ready is still high while the start pulse itself is on the bus.
                    if (!r_vr_start && !bus.vr_ready) begin
                        r_to_cnt <= '0;
                        r_state  <= ST_WAIT_HI;
                    end else if (w_timeout) begin
                        r_err     <= 1'b1;
                        r_vr_addr <= VR_ADDR_NONE;
                        r_state   <= ST_ERR;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                ST_WAIT_HI: begin
                    if (bus.vr_ready) begin
                        r_vr_addr <= VR_ADDR_NONE;
                        r_to_cnt  <= '0;
                        if (!r_homed) begin
                            if (r_home_cnt == MAX_V) begin
                                r_home_cnt <= '0;
                                if (r_ch == LAST_CH) begin
                                    r_homed <= 1'b1;
                                    r_state <= ST_SCAN;
                                end else begin
                                    r_ch    <= r_ch + 1'b1;
                                    r_state <= ST_HOME_SEL;
                                end
                            end else begin
                                r_home_cnt <= r_home_cnt + 1'b1;
                                r_state    <= ST_HOME_SEL;
                            end
                        end else begin
                            if (r_vr_ud) begin
                                if (r_pos[r_ch] != MAX_V) r_pos[r_ch] <= r_pos[r_ch] + 1'b1;
                            end else begin
                                if (r_pos[r_ch] != '0) r_pos[r_ch] <= r_pos[r_ch] - 1'b1;
                            end
                            r_state <= ST_SCAN;
                        end
                    end else if (w_timeout) begin
                        r_err     <= 1'b1;
                        r_vr_addr <= VR_ADDR_NONE;
                        r_state   <= ST_ERR;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                ST_ERR: begin
                    r_vr_addr <= VR_ADDR_NONE;
                end
                default: begin
                    r_err     <= 1'b1;
                    r_vr_addr <= VR_ADDR_NONE;
                    r_state   <= ST_ERR;
                end
            endcase
        end
    end

    assign bus.vr_addr  = r_vr_addr;
    assign bus.vr_ud    = r_vr_ud;
    assign bus.vr_start = r_vr_start;
    assign bus.busy     = r_busy;
    assign bus.homed    = r_homed;
    assign bus.err      = r_err;
    assign bus.rd_data  = r_rd_data;

endmodule

// File: tb/tb_vr_setpoint_ctrl.sv
// Bench for vr_setpoint_ctrl with a behavioural vr step engine; expected steps
// are queued when targets are written and checked on every vr_start.
module tb_vr_setpoint_ctrl;

    typedef struct packed {
        logic [2:0] addr;
        logic       ud;
    } step_t;

    typedef struct {
        logic [2:0] addr;
        logic [5:0] data;
        logic [5:0] exp_pos;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    step_t exp_q[$];
    step_t mon_exp;
    int    m_pos [6];

    // behavioural vr engine
    logic       stall;
    logic [5:0] dev_pos [6] = '{6'd5, 6'd14, 6'd23, 6'd32, 6'd41, 6'd50};
    logic [2:0] vr_cnt;
    logic [2:0] vr_addr_l;
    logic       vr_ud_l;

    vr_setpoint_ctrl_if bus ();

    vr_setpoint_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) begin
            bus.vr_ready <= 1'b1;
            vr_cnt       <= 3'd0;
        end else if (bus.vr_ready) begin
            if (bus.vr_start) begin
                bus.vr_ready <= 1'b0;
                vr_cnt       <= 3'd2;
                vr_addr_l    <= bus.vr_addr;
                vr_ud_l      <= bus.vr_ud;
            end
        end else if (!stall) begin
            if (vr_cnt == 3'd0) begin
                bus.vr_ready <= 1'b1;
                if (vr_addr_l < 3'd6) begin
                    if (vr_ud_l && dev_pos[vr_addr_l] != 6'd63)
                        dev_pos[vr_addr_l] <= dev_pos[vr_addr_l] + 6'd1;
                    else if (!vr_ud_l && dev_pos[vr_addr_l] != 6'd0)
                        dev_pos[vr_addr_l] <= dev_pos[vr_addr_l] - 6'd1;
                end
            end else begin
                vr_cnt <= vr_cnt - 3'd1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus.vr_start === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_start: got addr=%0d ud=%0d expected no step", bus.vr_addr, bus.vr_ud);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("step_addr_ud", {bus.vr_addr, bus.vr_ud}, mon_exp);
            end
        end
    end

    task automatic wr(input logic [2:0] a, input logic [5:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic push_steps(input logic [2:0] a, input int tgt);
        int n;
        n = (tgt > m_pos[a]) ? tgt - m_pos[a] : m_pos[a] - tgt;
        for (int unsigned k = 0; k < n; k++) exp_q.push_back('{addr: a, ud: (tgt > m_pos[a])});
        m_pos[a] = tgt;
    endtask

    task automatic push_home();
        for (int unsigned c = 0; c < 6; c++) begin
            for (int unsigned k = 0; k < 64; k++) exp_q.push_back('{addr: 3'(c), ud: 1'b0});
            m_pos[c] = 0;
        end
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        repeat (3) @(negedge clk);
        while ((bus.busy !== 1'b0 || bus.homed !== 1'b1) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk("idle_busy", bus.busy, 0);
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (bus.vr_start !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", bus.vr_start, 1);
    endtask

    task automatic rd_chk(input string nm, input logic [2:0] a, input logic [5:0] exp);
        bus.rd_addr = a;
        @(negedge clk);
        chk(nm, bus.rd_data, exp);
    endtask

    task automatic chk_reset_outs();
        chk("rst_vr_addr", bus.vr_addr, 7);
        chk("rst_vr_start", bus.vr_start, 0);
        chk("rst_vr_ud", bus.vr_ud, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_homed", bus.homed, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_rd_data", bus.rd_data, 0);
    endtask

    task automatic home_seq();
        int n;
        push_home();
        repeat (3) @(negedge clk);
        chk("homing_busy", bus.busy, 1);
        chk("homing_homed", bus.homed, 0);
        n = 0;
        while (bus.homed !== 1'b1 && n < 8000) begin
            @(negedge clk);
            n++;
        end
        chk("homed", bus.homed, 1);
        wait_idle(50);
        chk("home_queue_empty", exp_q.size(), 0);
    endtask

    vec_t vecs [8];

    initial begin
        vecs[0] = '{3'd2, 6'd3,  6'd3};
        vecs[1] = '{3'd1, 6'd63, 6'd63};
        vecs[2] = '{3'd1, 6'd60, 6'd60};
        vecs[3] = '{3'd5, 6'd1,  6'd1};
        vecs[4] = '{3'd6, 6'd9,  6'd0};
        vecs[5] = '{3'd7, 6'd5,  6'd0};
        vecs[6] = '{3'd5, 6'd0,  6'd0};
        vecs[7] = '{3'd2, 6'd3,  6'd3};

        reset       = 1'b1;
        stall       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_addr = '0;
        for (int unsigned c = 0; c < 6; c++) m_pos[c] = 0;
        repeat (3) @(negedge clk);
        chk_reset_outs();
        reset = 1'b0;

        // homing: 384 down steps, device wipers end at 0
        home_seq();
        for (int unsigned c = 0; c < 6; c++) chk("dev_homed", dev_pos[c], 0);

        // two channels pending together alternate 0,4,0,4
        exp_q.push_back('{3'd0, 1'b1});
        exp_q.push_back('{3'd4, 1'b1});
        exp_q.push_back('{3'd0, 1'b1});
        exp_q.push_back('{3'd4, 1'b1});
        m_pos[0] = 2;
        m_pos[4] = 2;
        wr(3'd0, 6'd2);
        wr(3'd4, 6'd2);
        wait_idle(500);
        rd_chk("rr_pos0", 3'd0, 6'd2);
        rd_chk("rr_pos4", 3'd4, 6'd2);
        chk("rr_queue_empty", exp_q.size(), 0);

        for (int unsigned i = 0; i < 8; i++) begin
            if (vecs[i].addr < 3'd6) push_steps(vecs[i].addr, int'(vecs[i].data));
            wr(vecs[i].addr, vecs[i].data);
            wait_idle(3000);
            rd_chk("vec_rd_data", vecs[i].addr, vecs[i].exp_pos);
            if (vecs[i].addr < 3'd6) chk("vec_dev_pos", dev_pos[vecs[i].addr], vecs[i].exp_pos);
            chk("vec_queue_empty", exp_q.size(), 0);
        end

        // target lowered while the first step is in flight: only that step runs
        exp_q.push_back('{3'd3, 1'b1});
        m_pos[3] = 1;
        wr(3'd3, 6'd2);
        wait_start();
        wr(3'd3, 6'd1);
        wait_idle(500);
        rd_chk("inflight_rd", 3'd3, 6'd1);
        chk("inflight_queue_empty", exp_q.size(), 0);

        // reset while a ch3 step sits in WAIT_HI
        push_steps(3'd3, 5);
        wr(3'd3, 6'd5);
        wait_start();
        repeat (2) @(negedge clk);
        chk("pre_rst_vr_ready", bus.vr_ready, 0);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk_reset_outs();
        reset = 1'b0;
        home_seq();
        rd_chk("rehome_pos3", 3'd3, 6'd0);

        // vr never returns ready: timeout parks in ERR
        stall = 1'b1;
        exp_q.push_back('{3'd0, 1'b1});
        wr(3'd0, 6'd5);
        wait_start();
        repeat (17) @(negedge clk);
        chk("err_not_yet", bus.err, 0);
        @(negedge clk);
        chk("err_set", bus.err, 1);
        chk("err_vr_addr", bus.vr_addr, 7);
        chk("err_busy", bus.busy, 1);
        repeat (20) @(negedge clk);
        chk("err_sticky", bus.err, 1);
        chk("err_no_start", bus.vr_start, 0);
        chk("err_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
